// File: rtl/mem_lsu_seq.sv
// mem_lsu_seq -- load/store stage between EX/MEM and MEM/WB.
//
// Each load or store is serialised into 1..DATA_W/8 single-byte accesses on a
// byte-wide synchronous RAM port, and the front of the pipeline is held with
// stall_o until the access is complete. Loads are little-endian and are sign-
// or zero-extended. Non-memory instructions pass straight through.
//
// Ports
//   clk, rst        clock, synchronous active-high reset (all outputs 0 while rst=1)
//   mem_en_i        instruction is a load/store
//   mem_we_i        1=store, 0=load
//   mem_size_i      log2 of access size in bytes (0=B 1=H 2=W 3=D)
//   mem_unsigned_i  zero-extend the loaded value
//   mem_addr_i      byte address, any alignment (wraps modulo 2^ADDR_W)
//   mem_data_i      store data
//   wd_i, wreg_i    destination register / write enable from EX/MEM
//   wdata_i         ALU result for the non-memory path
//   ram_din_i       read byte, valid one cycle after its address
//   ram_addr_o      RAM byte address (0 outside a transfer)
//   ram_dout_o      store byte (0 outside a transfer)
//   ram_wr_o        write strobe for ram_dout_o at ram_addr_o
//   wd_o, wreg_o    destination register / write enable to MEM/WB
//   wdata_o         result to MEM/WB
//   stall_o         hold IF..EX/MEM this cycle
//   err_o           one-cycle pulse: access wider than DATA_W
module mem_lsu_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int         NB   = DATA_W / 8;
  localparam logic [3:0] NB_L = 4'(NB);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  state_t            state_p0, state_d;
  logic [3:0]        cnt_p0, cnt_d;
  logic              err_p0, err_d;

  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] rdata_p0;
  logic              we_p0;
  logic              uns_p0;
  logic [1:0]        size_p0;
  logic [REG_AW-1:0] wd_p0;
  logic              wreg_p0;

  logic [3:0]        n_in, n_p0;
  logic              size_err, last_byte;
  logic              cap_en;
  logic [3:0]        cap_idx;

  // Sign- or zero-extend the low 8<<sz bits of raw to DATA_W bits.
  // A full-width access needs no extension.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                  input logic [1:0] sz,
                                                  input logic uns);
    logic signed [DATA_W-1:0] top;
    int sh;
    sh = DATA_W - (8 << sz);
    if (sh <= 0) return raw;
    top = raw << sh;
    if (uns) return (raw << sh) >> sh;
    return top >>> sh;
  endfunction

  assign n_in      = 4'd1 << mem_size_i;
  assign n_p0      = 4'd1 << size_p0;
  assign size_err  = n_in > NB_L;
  assign last_byte = (cnt_p0 == n_p0 - 4'd1);

  // Read data lags its address by one cycle: in XFER byte cnt-1 arrives,
  // and the final byte arrives in WAIT.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = cnt_p0 - 4'd1;
    if (state_p0 == XFER && !we_p0 && cnt_p0 != 4'd0) begin
      cap_en = 1'b1;
    end else if (state_p0 == WAIT) begin
      cap_en  = 1'b1;
      cap_idx = n_p0 - 4'd1;
    end
  end

  // ---- p0: control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      err_p0   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      err_p0   <= err_d;
    end
  end

  // ---- p0: latched request and assembled load data ----
  always_ff @(posedge clk) begin
    if (state_p0 == IDLE && mem_en_i) begin
      addr_p0 <= mem_addr_i;
      data_p0 <= mem_data_i;
      we_p0   <= mem_we_i;
      size_p0 <= mem_size_i;
      uns_p0  <= mem_unsigned_i;
      wd_p0   <= wd_i;
      wreg_p0 <= wreg_i;
    end
    for (int b = 0; b < NB; b++) begin
      if (cap_en && cap_idx == 4'(b)) rdata_p0[8*b +: 8] <= ram_din_i;
    end
  end

  always_comb begin
    state_d    = state_p0;
    cnt_d      = cnt_p0;
    err_d      = err_p0;
    ram_addr_o = '0;
    ram_dout_o = '0;
    ram_wr_o   = 1'b0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stall_o    = 1'b0;
    err_o      = 1'b0;
    case (state_p0)
      IDLE: begin
        if (mem_en_i) begin
          stall_o = 1'b1;
          cnt_d   = '0;
          err_d   = size_err;
          state_d = size_err ? DONE : XFER;
        end else begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      XFER: begin
        stall_o    = 1'b1;
        ram_addr_o = addr_p0 + ADDR_W'(cnt_p0);
        if (we_p0) begin
          ram_wr_o   = 1'b1;
          ram_dout_o = 8'(data_p0 >> {cnt_p0, 3'b000});
        end
        cnt_d = cnt_p0 + 4'd1;
        if (last_byte) state_d = we_p0 ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // The instruction is still presented this cycle; returning to IDLE
        // unconditionally lets the pipeline advance past it.
        state_d = IDLE;
        wd_o    = wd_p0;
        if (err_p0) begin
          err_o = 1'b1;
        end else if (!we_p0) begin
          wreg_o  = wreg_p0;
          wdata_o = load_ext(rdata_p0, size_p0, uns_p0);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      ram_addr_o = '0;
      ram_dout_o = '0;
      ram_wr_o   = 1'b0;
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stall_o    = 1'b0;
      err_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu_seq.sv
module tb_mem_lsu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_en, mem_we, mem_uns, wreg_i;
  logic [1:0]  mem_size;
  logic [16:0] mem_addr;
  logic [63:0] mem_data, wdata_i;
  logic [4:0]  wd_i;

  logic [7:0]  ram_din, ram_dout, ram_din64, ram_dout64;
  logic [16:0] ram_addr, ram_addr64;
  logic        ram_wr, ram_wr64;
  logic [4:0]  wd_o, wd64;
  logic        wreg_o, wreg64, stall, stall64, err, err64;
  logic [31:0] wdata_o;
  logic [63:0] wdata64;

  mem_lsu_seq #(.DATA_W(32), .ADDR_W(17), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en), .mem_we_i(mem_we),
    .mem_size_i(mem_size), .mem_unsigned_i(mem_uns), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data[31:0]), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i[31:0]), .ram_din_i(ram_din), .ram_addr_o(ram_addr),
    .ram_dout_o(ram_dout), .ram_wr_o(ram_wr), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stall_o(stall), .err_o(err)
  );

  mem_lsu_seq #(.DATA_W(64), .ADDR_W(17), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst), .mem_en_i(mem_en), .mem_we_i(mem_we),
    .mem_size_i(mem_size), .mem_unsigned_i(mem_uns), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .ram_din_i(ram_din64), .ram_addr_o(ram_addr64),
    .ram_dout_o(ram_dout64), .ram_wr_o(ram_wr64), .wd_o(wd64), .wreg_o(wreg64),
    .wdata_o(wdata64), .stall_o(stall64), .err_o(err64)
  );

  // Byte-wide synchronous RAM models; pre_* lets the bench preload bytes.
  logic [7:0]  mem   [0:131071];
  logic [7:0]  mem64 [0:255];
  logic        pre_we, pre64_we;
  logic [16:0] pre_a;
  logic [7:0]  pre_d;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (ram_wr) mem[ram_addr] <= ram_dout;
    ram_din <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (pre64_we) mem64[pre_a[7:0]] <= pre_d;
    else if (ram_wr64) mem64[ram_addr64[7:0]] <= ram_dout64;
    ram_din64 <= mem64[ram_addr64[7:0]];
  end

  typedef struct packed { logic [16:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [63:0] wdata; logic [4:0] wd; logic wreg; logic err; int stalls; } res_t;

  wr_t  wr_q[$];
  res_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  wr_t  mw;

  // Every RAM write of the 32-bit DUT must match the next expected write.
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      tests++;
      if (wr_q.size() == 0) begin
        failed++;
        $display("FAIL ram_write: unexpected write addr=%h data=%h, want none", ram_addr, ram_dout);
      end else begin
        mw = wr_q.pop_front();
        if (ram_addr !== mw.a || ram_dout !== mw.d) begin
          failed++;
          $display("FAIL ram_write: got addr=%h data=%h, want addr=%h data=%h",
                   ram_addr, ram_dout, mw.a, mw.d);
        end
      end
    end
  end

  task automatic poke(input bit s64, input logic [16:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_we = !s64; pre64_we = s64; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0; pre64_we = 1'b0;
  endtask

  // Present one memory instruction, hold it until the selected DUT drops
  // stall, capture the DONE-cycle outputs, then retire it.
  task automatic drive_op(input bit s64, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [16:0] a,
                          input logic [63:0] d, input logic [4:0] wd,
                          output res_t obs);
    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = we; mem_size = sz; mem_uns = uns; mem_addr = a;
    mem_data = d; wd_i = wd; wreg_i = 1'b1; wdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    obs.stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((s64 ? stall64 : stall) === 1'b1) obs.stalls++;
      else break;
    end
    obs.wdata = s64 ? wdata64 : {32'h0, wdata_o};
    obs.wd    = s64 ? wd64 : wd_o;
    obs.wreg  = s64 ? wreg64 : wreg_o;
    obs.err   = s64 ? err64 : err;
    @(posedge clk); #1;
    mem_en = 1'b0; wreg_i = 1'b0;
  endtask

  task automatic test_reset;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (wdata_o !== 32'h0 || wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata64 !== 64'h0) begin
      failed++;
      $display("FAIL reset_result: got wdata=%h wd=%0d wreg=%b wdata64=%h, want all 0",
               wdata_o, wd_o, wreg_o, wdata64);
    end
    tests++;
    if (stall !== 1'b0 || ram_wr !== 1'b0 || err !== 1'b0 || ram_addr !== 17'h0) begin
      failed++;
      $display("FAIL reset_ctrl: got stall=%b ram_wr=%b err=%b ram_addr=%h, want 0",
               stall, ram_wr, err, ram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; wreg_i = 1'b0;
  endtask

  task automatic test_passthrough;
    logic [4:0]  wds [2] = '{5'd5, 5'd17};
    logic [31:0] wvs [2] = '{32'h0000_1234, 32'hFFFF_0000};
    logic        wes [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      mem_en = 1'b0; wd_i = wds[k]; wreg_i = wes[k]; wdata_i = {32'h0, wvs[k]};
      @(negedge clk);
      tests++;
      if (wd_o !== wds[k] || wdata_o !== wvs[k] || wreg_o !== wes[k] ||
          stall !== 1'b0 || ram_wr !== 1'b0) begin
        failed++;
        $display("FAIL passthrough%0d: got wd=%0d wdata=%h wreg=%b stall=%b ram_wr=%b, want wd=%0d wdata=%h wreg=%b stall=0 ram_wr=0",
                 k, wd_o, wdata_o, wreg_o, stall, ram_wr, wds[k], wvs[k], wes[k]);
      end
    end
    wreg_i = 1'b0;
  endtask

  task automatic test_store;
    res_t obs, e;
    logic [31:0] sd = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) wr_q.push_back('{a: 17'h101 + 17'(k), d: 8'(sd >> (8*k))});
    sb.push_back('{wdata: 64'h0, wd: 5'd9, wreg: 1'b0, err: 1'b0, stalls: 5});
    drive_op(1'b0, 1'b1, 2'd2, 1'b0, 17'h00101, {32'h0, sd}, 5'd9, obs);
    e = sb.pop_front();
    tests++;
    if (obs.wdata !== e.wdata || obs.wd !== e.wd || obs.wreg !== e.wreg || obs.err !== e.err) begin
      failed++;
      $display("FAIL sw_result: got wdata=%h wd=%0d wreg=%b err=%b, want wdata=%h wd=%0d wreg=%b err=%b",
               obs.wdata, obs.wd, obs.wreg, obs.err, e.wdata, e.wd, e.wreg, e.err);
    end
    tests++;
    if (obs.stalls != e.stalls) begin
      failed++;
      $display("FAIL sw_stalls: got %0d, want %0d", obs.stalls, e.stalls);
    end
    tests++;
    if (wr_q.size() != 0) begin
      failed++;
      $display("FAIL sw_writes: %0d expected writes missing, want 0", wr_q.size());
    end
  endtask

  // Loads on the 32-bit DUT: table of {addr, size, unsigned, expected, stalls}.
  task automatic run_loads(input string name, input int n, input logic [16:0] as [4],
                           input logic [1:0] szs [4], input logic us [4],
                           input logic [31:0] exps [4], input int sts [4]);
    res_t obs, e;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{wdata: {32'h0, exps[k]}, wd: 5'(k + 3), wreg: 1'b1, err: 1'b0, stalls: sts[k]});
      drive_op(1'b0, 1'b0, szs[k], us[k], as[k], 64'h0, 5'(k + 3), obs);
      e = sb.pop_front();
      tests++;
      if (obs.wdata !== e.wdata || obs.wd !== e.wd || obs.wreg !== e.wreg || obs.err !== e.err) begin
        failed++;
        $display("FAIL %s%0d_result: got wdata=%h wd=%0d wreg=%b err=%b, want wdata=%h wd=%0d wreg=%b err=%b",
                 name, k, obs.wdata, obs.wd, obs.wreg, obs.err, e.wdata, e.wd, e.wreg, e.err);
      end
      tests++;
      if (obs.stalls != e.stalls) begin
        failed++;
        $display("FAIL %s%0d_stalls: got %0d, want %0d", name, k, obs.stalls, e.stalls);
      end
    end
  endtask

  task automatic test_load_byte;
    poke(1'b0, 17'h00050, 8'h80);
    run_loads("lb", 2, '{17'h50, 17'h50, 17'h0, 17'h0}, '{2'd0, 2'd0, 2'd0, 2'd0},
              '{1'b0, 1'b1, 1'b0, 1'b0}, '{32'hFFFFFF80, 32'h00000080, 32'h0, 32'h0},
              '{3, 3, 0, 0});
  endtask

  task automatic test_load_wrap;
    poke(1'b0, 17'h1FFFF, 8'h34);
    poke(1'b0, 17'h00000, 8'h92);
    run_loads("lh_wrap", 2, '{17'h1FFFF, 17'h1FFFF, 17'h0, 17'h0}, '{2'd1, 2'd1, 2'd0, 2'd0},
              '{1'b0, 1'b1, 1'b0, 1'b0}, '{32'hFFFF9234, 32'h00009234, 32'h0, 32'h0},
              '{4, 4, 0, 0});
  endtask

  task automatic test_load_word;
    poke(1'b0, 17'h00300, 8'h78);
    poke(1'b0, 17'h00301, 8'h56);
    poke(1'b0, 17'h00302, 8'h34);
    poke(1'b0, 17'h00303, 8'hF2);
    run_loads("lw", 2, '{17'h300, 17'h300, 17'h0, 17'h0}, '{2'd2, 2'd2, 2'd0, 2'd0},
              '{1'b0, 1'b1, 1'b0, 1'b0}, '{32'hF2345678, 32'hF2345678, 32'h0, 32'h0},
              '{6, 6, 0, 0});
  endtask

  task automatic test_ld64;
    res_t obs, e;
    logic [16:0] as  [2] = '{17'h10, 17'h20};
    logic [1:0]  szs [2] = '{2'd3, 2'd2};
    logic [7:0]  hi  [4] = '{8'h05, 8'h06, 8'h07, 8'h88};
    for (int k = 0; k < 8; k++) poke(1'b1, 17'h10 + 17'(k), 8'(k + 1));
    for (int k = 0; k < 4; k++) poke(1'b1, 17'h20 + 17'(k), hi[k]);
    sb.push_back('{wdata: 64'h0807060504030201, wd: 5'd10, wreg: 1'b1, err: 1'b0, stalls: 10});
    sb.push_back('{wdata: 64'hFFFFFFFF88070605, wd: 5'd11, wreg: 1'b1, err: 1'b0, stalls: 6});
    for (int k = 0; k < 2; k++) begin
      drive_op(1'b1, 1'b0, szs[k], 1'b0, as[k], 64'h0, 5'(10 + k), obs);
      e = sb.pop_front();
      tests++;
      if (obs.wdata !== e.wdata || obs.wd !== e.wd || obs.wreg !== e.wreg || obs.err !== e.err) begin
        failed++;
        $display("FAIL ld64_%0d_result: got wdata=%h wd=%0d wreg=%b err=%b, want wdata=%h wd=%0d wreg=%b err=%b",
                 k, obs.wdata, obs.wd, obs.wreg, obs.err, e.wdata, e.wd, e.wreg, e.err);
      end
      tests++;
      if (obs.stalls != e.stalls) begin
        failed++;
        $display("FAIL ld64_%0d_stalls: got %0d, want %0d", k, obs.stalls, e.stalls);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_size_err;
    res_t obs, e;
    sb.push_back('{wdata: 64'h0, wd: 5'd4, wreg: 1'b0, err: 1'b1, stalls: 1});
    drive_op(1'b0, 1'b1, 2'd3, 1'b0, 17'h00400, 64'h1122334455667788, 5'd4, obs);
    e = sb.pop_front();
    tests++;
    if (obs.wdata !== e.wdata || obs.wd !== e.wd || obs.wreg !== e.wreg || obs.err !== e.err) begin
      failed++;
      $display("FAIL err_result: got wdata=%h wd=%0d wreg=%b err=%b, want wdata=%h wd=%0d wreg=%b err=%b",
               obs.wdata, obs.wd, obs.wreg, obs.err, e.wdata, e.wd, e.wreg, e.err);
    end
    tests++;
    if (obs.stalls != e.stalls) begin
      failed++;
      $display("FAIL err_stalls: got %0d, want %0d", obs.stalls, e.stalls);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      failed++;
      $display("FAIL err_pulse: got err=%b one cycle later, want 0", err);
    end
    // The 64-bit instance performs this access for real; let it finish.
    repeat (12) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    res_t obs, e;
    sb.push_back('{wdata: 64'h80, wd: 5'd12, wreg: 1'b1, err: 1'b0, stalls: 3});
    drive_op(1'b0, 1'b0, 2'd0, 1'b1, 17'h00050, 64'h0, 5'd12, obs);
    e = sb.pop_front();
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 64'hA5A5;
    tests++;
    if (obs.wdata !== e.wdata || obs.wreg !== e.wreg || obs.stalls != e.stalls) begin
      failed++;
      $display("FAIL b2b_load: got wdata=%h wreg=%b stalls=%0d, want wdata=%h wreg=%b stalls=%0d",
               obs.wdata, obs.wreg, obs.stalls, e.wdata, e.wreg, e.stalls);
    end
    @(negedge clk);
    tests++;
    if (wd_o !== 5'd3 || wreg_o !== 1'b1 || wdata_o !== 32'hA5A5 || stall !== 1'b0) begin
      failed++;
      $display("FAIL b2b_alu: got wd=%0d wreg=%b wdata=%h stall=%b, want wd=3 wreg=1 wdata=0000a5a5 stall=0",
               wd_o, wreg_o, wdata_o, stall);
    end
    wreg_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) poke(1'b0, 17'h200 + 17'(k), 8'h11);
    wr_q.push_back('{a: 17'h200, d: 8'hEF});
    wr_q.push_back('{a: 17'h201, d: 8'hBE});
    @(posedge clk); #1;
    mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_uns = 1'b0;
    mem_addr = 17'h00200; mem_data = 64'hDEADBEEF; wd_i = 5'd1; wreg_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 17'h0) begin
      failed++;
      $display("FAIL rst_mid_during: got stall=%b ram_wr=%b ram_addr=%h, want 0", stall, ram_wr, ram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0; wreg_i = 1'b0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || ram_wr !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_after: got stall=%b ram_wr=%b, want 0", stall, ram_wr);
    end
    repeat (3) @(posedge clk);
    tests++;
    if (mem[17'h200] !== 8'hEF || mem[17'h201] !== 8'hBE ||
        mem[17'h202] !== 8'h11 || mem[17'h203] !== 8'h11) begin
      failed++;
      $display("FAIL rst_mid_ram: got %h %h %h %h, want ef be 11 11",
               mem[17'h200], mem[17'h201], mem[17'h202], mem[17'h203]);
    end
    tests++;
    if (wr_q.size() != 0) begin
      failed++;
      $display("FAIL rst_mid_writes: %0d expected writes missing, want 0", wr_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_uns = 1'b0;
    mem_addr = '0; mem_data = '0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    pre_we = 1'b0; pre64_we = 1'b0; pre_a = '0; pre_d = '0;
    test_reset;
    test_passthrough;
    test_store;
    test_load_byte;
    test_load_wrap;
    test_load_word;
    test_ld64;
    test_size_err;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
